// File: rtl/alu_pkg.sv
// Shared ALU opcodes, FSM state encoding and the single-cycle result helper
// used by alu_seq_exec.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath: one partial product per step.
// With ALU_MUL_EARLY_TERM_EN defined, the last step is flagged as soon as the remaining multiplier is zero.
module alu_mul_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] mcand_i,
   input  logic [WIDTH-1:0] mplier_i,
   output logic [WIDTH-1:0] acc_next_o,
   output logic             last_o
);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mplier_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   // acc_next_o already includes this step's partial product, so the owner can latch it on the last edge.
   always_comb begin
      acc_next_o   = acc_q + (mplier_q[0] ? mcand_q : '0);
      mplier_shift = mplier_q >> 1;
`ifdef ALU_MUL_EARLY_TERM_EN
      last_o = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shift == '0);
`else
      last_o = (cnt_q == CNT_W'(WIDTH - 1));
`endif
   end

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         mcand_d  = mcand_i;
         mplier_d = mplier_i;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step_i) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_shift;
         acc_d    = acc_next_o;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops plus a stalling iterative MUL.
// Optional build macro ALU_MUL_EARLY_TERM_EN enables early multiply termination.
module alu_seq_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             out_valid,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] single_res;
   logic [WIDTH-1:0] mul_acc_next;
   logic             mul_last;
   logic             mul_start, mul_step;
   logic             accept, is_mul;

   assign accept = in_valid && in_ready;
   assign is_mul = (ALUControl == ALU_MUL);

   alu_mul_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (mul_start),
      .step_i     (mul_step),
      .mcand_i    (SrcA),
      .mplier_i   (SrcB),
      .acc_next_o (mul_acc_next),
      .last_o     (mul_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
         ST_MUL:  if (mul_last) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      mul_start = 1'b0;
      mul_step  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready  = 1'b1;
            mul_start = accept && is_mul;
         end
         ST_MUL: begin
            busy     = 1'b1;
            mul_step = 1'b1;
         end
         default: ;
      endcase
   end

   // Unlisted codes (011, 111) fall through to ADD.
   always_comb begin
      case (ALUControl)
         ALU_AND: single_res = SrcA & SrcB;
         ALU_OR:  single_res = SrcA | SrcB;
         ALU_SUB: single_res = SrcA - SrcB;
         ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         default: single_res = SrcA + SrcB;
      endcase
   end

   always_comb begin
      result_d    = result_q;
      zero_d      = zero_q;
      out_valid_d = 1'b0;
      if (state_q == ST_IDLE && accept && !is_mul) begin
         result_d    = single_res;
         zero_d      = (single_res == '0);
         out_valid_d = 1'b1;
      end else if (state_q == ST_MUL && mul_last) begin
         result_d    = mul_acc_next;
         zero_d      = (mul_acc_next == '0);
         out_valid_d = 1'b1;
      end
   end

   assign ALUResult = result_q;
   assign Zero      = zero_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec (WIDTH=32), aware of ALU_MUL_EARLY_TERM_EN.
module tb_alu_seq_exec;
   import alu_pkg::*;

   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        ALUControl = 3'b000;
   logic [WIDTH-1:0]  SrcA = '0;
   logic [WIDTH-1:0]  SrcB = '0;
   logic              out_valid;
   logic [WIDTH-1:0]  ALUResult;
   logic              Zero;
   logic              busy;

   int tests_run = 0;
   int tests_failed = 0;

   alu_seq_exec #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUControl (ALUControl),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .out_valid  (out_valid),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected accept-to-out_valid latency for a MUL with multiplier b.
   function automatic int exp_mul_lat(input logic [WIDTH-1:0] b);
`ifdef ALU_MUL_EARLY_TERM_EN
      int n;
      n = 1;
      for (int i = 0; i < WIDTH; i++) if (b[i]) n = i + 1;
      return n + 1;
`else
      return WIDTH + 1;
`endif
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      tick();
      tick();
      tests_run++;
      if (ALUResult !== 32'h0 || Zero !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: result=%h zero=%b ov=%b busy=%b, required 0/0/0/0",
                  ALUResult, Zero, out_valid, busy);
      end
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
      end
      $display("[TB] reset: result=%h zero=%b in_ready=%b", ALUResult, Zero, in_ready);
   endtask

   task automatic test_reset_mid_mul();
      bit saw_ov;
      bit ready_ok;
      in_valid = 1'b1; ALUControl = ALU_ADD; SrcA = 32'd5; SrcB = 32'd6;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd11) begin
         tests_failed++;
         $display("FAIL pre_reset_add: ov=%b result=%h, required 1/0000000b", out_valid, ALUResult);
      end
      in_valid = 1'b1; ALUControl = ALU_MUL; SrcA = 32'd7; SrcB = 32'd9;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (ALUResult !== 32'h0 || Zero !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset_mid_mul: result=%h zero=%b ov=%b busy=%b, required 0/0/0/0",
                  ALUResult, Zero, out_valid, busy);
      end
      tick();
      rst_n = 1'b1;
      saw_ov = 1'b0;
      ready_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid) saw_ov = 1'b1;
         if (!in_ready) ready_ok = 1'b0;
      end
      tests_run++;
      if (saw_ov || !ready_ok || ALUResult !== 32'h0) begin
         tests_failed++;
         $display("FAIL abandoned_mul: saw_ov=%b ready_ok=%b result=%h, required 0/1/00000000",
                  saw_ov, ready_ok, ALUResult);
      end
      $display("[TB] reset mid-MUL: saw_ov=%b in_ready=%b result=%h", saw_ov, in_ready, ALUResult);
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; ALUControl = ALU_ADD; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_add: ov=%b result=%h zero=%b, required 1/00000000/1", out_valid, ALUResult, Zero);
      end
      $display("[TB] ADD ffffffff+1 -> %h zero=%b", ALUResult, Zero);
      ALUControl = ALU_SUB; SrcA = 32'd5; SrcB = 32'd7;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || ALUResult !== 32'hFFFF_FFFE || Zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_sub: ov=%b result=%h zero=%b, required 1/fffffffe/0", out_valid, ALUResult, Zero);
      end
      $display("[TB] SUB 5-7 -> %h", ALUResult);
      ALUControl = ALU_SLT; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd1) begin
         tests_failed++;
         $display("FAIL b2b_slt: ov=%b result=%h, required 1/00000001", out_valid, ALUResult);
      end
      $display("[TB] SLT -1<1 -> %h", ALUResult);
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || ALUResult !== 32'd1) begin
         tests_failed++;
         $display("FAIL b2b_idle: ov=%b result=%h, required 0/00000001", out_valid, ALUResult);
      end
   endtask

   task automatic test_logic_ops();
      in_valid = 1'b1; ALUControl = ALU_AND; SrcA = 32'hF0F0_1234; SrcB = 32'h0FF0_FF00;
      tick();
      tests_run++;
      if (ALUResult !== 32'h00F0_1200) begin
         tests_failed++;
         $display("FAIL and: result=%h, required 00f01200", ALUResult);
      end
      $display("[TB] AND -> %h", ALUResult);
      ALUControl = ALU_OR;
      tick();
      tests_run++;
      if (ALUResult !== 32'hFFF0_FF34) begin
         tests_failed++;
         $display("FAIL or: result=%h, required fff0ff34", ALUResult);
      end
      $display("[TB] OR -> %h", ALUResult);
      ALUControl = 3'b111; SrcA = 32'd10; SrcB = 32'd20;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (ALUResult !== 32'd30) begin
         tests_failed++;
         $display("FAIL code111_add: result=%h, required 0000001e", ALUResult);
      end
      $display("[TB] code 111 -> %h", ALUResult);
   endtask

   task automatic test_mul(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] expv);
      logic [WIDTH-1:0] prev;
      int lat, busy_cnt, want_lat;
      bit seen, stable;
      prev = ALUResult;
      want_lat = exp_mul_lat(b);
      in_valid = 1'b1; ALUControl = ALU_MUL; SrcA = a; SrcB = b;
      tick();
      in_valid = 1'b0;
      lat = 1; busy_cnt = 0; seen = 1'b0; stable = 1'b1;
      while (!seen && lat <= 100) begin
         if (out_valid) seen = 1'b1;
         else begin
            if (busy && !in_ready) busy_cnt++;
            if (ALUResult !== prev) stable = 1'b0;
            tick();
            lat++;
         end
      end
      tests_run++;
      if (!seen || lat != want_lat) begin
         tests_failed++;
         $display("FAIL %s_latency: seen=%b latency=%0d, required %0d", name, seen, lat, want_lat);
      end
      tests_run++;
      if (ALUResult !== expv || Zero !== (expv == '0)) begin
         tests_failed++;
         $display("FAIL %s_result: result=%h zero=%b, required %h/%b", name, ALUResult, Zero, expv, expv == '0);
      end
      tests_run++;
      if (busy_cnt != want_lat - 1 || !stable || busy !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_handshake: busy_cycles=%0d stable=%b busy=%b ready=%b, required %0d/1/0/1",
                  name, busy_cnt, stable, busy, in_ready, want_lat - 1);
      end
      $display("[TB] MUL %s: %h*%h -> %h latency=%0d", name, a, b, ALUResult, lat);
      tick();
   endtask

   task automatic test_request_during_busy();
      int lat, want_lat;
      bit seen, early;
      want_lat = exp_mul_lat(32'd4);
      in_valid = 1'b1; ALUControl = ALU_MUL; SrcA = 32'd3; SrcB = 32'd4;
      tick();
      ALUControl = ALU_ADD; SrcA = 32'd1; SrcB = 32'd1;
      lat = 1; seen = 1'b0; early = 1'b0;
      while (!seen && lat <= 100) begin
         if (out_valid) seen = 1'b1;
         else begin
            if (ALUResult === 32'd2) early = 1'b1;
            tick();
            lat++;
         end
      end
      tests_run++;
      if (!seen || lat != want_lat || ALUResult !== 32'd12 || early) begin
         tests_failed++;
         $display("FAIL busy_hold_mul: seen=%b latency=%0d result=%h early=%b, required 1/%0d/0000000c/0",
                  seen, lat, ALUResult, early, want_lat);
      end
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd2) begin
         tests_failed++;
         $display("FAIL busy_hold_add: ov=%b result=%h, required 1/00000002", out_valid, ALUResult);
      end
      $display("[TB] held ADD after MUL: result=%h", ALUResult);
      tick();
   endtask

   initial begin
      test_reset();
      test_reset_mid_mul();
      test_back_to_back();
      test_logic_ops();
      test_mul("wide", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
      test_mul("overflow", 32'h8000_0000, 32'd2, 32'h0000_0000);
      test_mul("neg", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
      test_mul("small", 32'd1234, 32'd3, 32'd3702);
      test_mul("by_zero", 32'd77, 32'd0, 32'd0);
      test_mul("by_one", 32'd77, 32'd1, 32'd77);
      test_request_during_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
